sram_matrix_loader: RTL

- Write-side counterpart to the attention compute block's SRAM read port. It fills one input SRAM or one weight SRAM from a valid/ready word stream.
- SRAM layout produced: header word at address 0 = {rows[15:0], cols[15:0]}; elements packed contiguously from address 1, in stream order.
- Once the image is complete, the block launches the compute block through its dut_valid/dut_ready handshake and waits for completion.
- One instance per SRAM. Input SRAM uses NUM_MAT=1; weight SRAM uses NUM_MAT=3 (Wq, Wk, Wv back-to-back, sharing one header).

---
 rtl/sram_matrix_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_matrix_loader.sv
// sram_matrix_loader: fills one SRAM with {rows,cols} header plus stream words, then launches the compute block.
// Optional LOADER_CHECKSUM_EN adds load_checksum, the running 32-bit sum of every word written.
module sram_matrix_loader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int NUM_MAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [15:0]       load_rows,
  input  logic [15:0]       load_cols,
  output logic              load_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              busy,
  output logic              load_done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       load_checksum
`endif
);
  localparam int NW = 32 + $clog2(NUM_MAT + 1);
  localparam logic [NW-1:0] MAXN = NW'((64'(1) << ADDR_W) - 64'(1));
  typedef enum logic [2:0] {IDLE, HDR, DATA, LAUNCH, RUN, DONE} state_t;
  state_t state;
  logic [15:0] rows, cols;
  logic [ADDR_W-1:0] n, cnt, cnt_nxt;
  logic [NW-1:0] n_full;
  logic bad, seen_low;
  assign n_full = NW'(load_rows) * NW'(load_cols) * NW'(NUM_MAT);
  assign bad = load_rows == 16'd0 || load_cols == 16'd0 || n_full > MAXN;
  assign cnt_nxt = cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rows <= '0;
      cols <= '0;
      n <= '0;
      cnt <= '0;
      seen_low <= 1'b0;
      load_err <= 1'b0;
      in_ready <= 1'b0;
      sram_write_enable <= 1'b0;
      sram_write_address <= '0;
      sram_write_data <= '0;
      dut_valid <= 1'b0;
      busy <= 1'b0;
      load_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_checksum <= '0;
`endif
    end else begin
      load_err <= 1'b0;
      sram_write_enable <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          if (bad) load_err <= 1'b1;
          else begin
            rows <= load_rows;
            cols <= load_cols;
            n <= n_full[ADDR_W-1:0];
            cnt <= '0;
            busy <= 1'b1;
            state <= HDR;
          end
        end
        HDR: begin
          sram_write_enable <= 1'b1;
          sram_write_address <= '0;
          sram_write_data <= DATA_W'({rows, cols});
          in_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          load_checksum <= {rows, cols};
`endif
          state <= DATA;
        end
        DATA: if (in_valid && in_ready) begin
          sram_write_enable <= 1'b1;
          sram_write_address <= cnt_nxt;
          sram_write_data <= in_data;
          cnt <= cnt_nxt;
`ifdef LOADER_CHECKSUM_EN
          load_checksum <= load_checksum + in_data[31:0];
`endif
          if (cnt_nxt == n) begin
            in_ready <= 1'b0;
            dut_valid <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: if (dut_ready) begin
          dut_valid <= 1'b0;
          seen_low <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          if (!dut_ready) seen_low <= 1'b1;
          else if (seen_low) begin
            load_done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
